// File: rtl/regfile_sb_if.sv
// Register-file port bundle: two read ports with scoreboard status, one write port, and one scoreboard issue port.
// slave = register file side, master = pipeline (decode/writeback) side.
interface regfile_sb_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              READY;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [XLEN-1:0]   RD1;
  logic [XLEN-1:0]   RD2;
  logic              BUSY1;
  logic              BUSY2;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [XLEN-1:0]   WD3;
  logic              SB_SET;
  logic [ADDR_W-1:0] ASB;

  modport slave (
    output READY, RD1, RD2, BUSY1, BUSY2,
    input  A1, A2, WE3, A3, WD3, SB_SET, ASB
  );

  modport master (
    input  READY, RD1, RD2, BUSY1, BUSY2,
    output A1, A2, WE3, A3, WD3, SB_SET, ASB
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a pending-write scoreboard and a post-reset clearing sweep.
// Define REGFILE_BYPASS_EN to forward the write port to the read ports in the same cycle.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          CLK,
  input  logic          RST,
  regfile_sb_if.slave   bus,
  output logic          dbg_state
);
  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   cnt;
  logic [XLEN-1:0]   mem [NREGS];
  logic [NREGS-1:0]  pend;
  logic              we_eff, set_eff;
  logic [ADDR_W-1:0] a3;
  logic [XLEN-1:0]   wd3;

  assign a3      = bus.A3;
  assign wd3     = bus.WD3;
  assign we_eff  = (state == RUN) && bus.WE3 && !((ZERO_REG != 0) && (bus.A3 == '0));
  assign set_eff = (state == RUN) && bus.SB_SET && !((ZERO_REG != 0) && (bus.ASB == '0));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= INIT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (cnt[ADDR_W-1:0] == {ADDR_W{1'b1}}) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  always_comb begin
    bus.READY = (state == RUN);
    dbg_state = state;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)               cnt <= '0;
    else if (state == INIT) cnt <= cnt + {{ADDR_W{1'b0}}, 1'b1};
  end

  // Storage carries no reset; the sweep zeroes it before READY rises.
  always_ff @(posedge CLK) begin
    if (state == INIT) mem[cnt[ADDR_W-1:0]] <= '0;
    else if (we_eff)   mem[a3] <= wd3;
  end

  // Set is applied after clear so a same-address issue wins over the writeback.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend <= '0;
    end else begin
      if (we_eff)  pend[a3]      <= 1'b0;
      if (set_eff) pend[bus.ASB] <= 1'b1;
    end
  end

  function automatic logic [XLEN:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [XLEN:0] r;
    r = {pend[a], mem[a]};
    if (state != RUN) r = '0;
    else if ((ZERO_REG != 0) && (a == '0)) r = '0;
`ifdef REGFILE_BYPASS_EN
    else if (we_eff && (a3 == a)) r = {1'b0, wd3};
`else
    else r = {pend[a], mem[a]};
`endif
    return r;
  endfunction

  always_comb begin
    {bus.BUSY1, bus.RD1} = rd_port(bus.A1);
    {bus.BUSY2, bus.RD2} = rd_port(bus.A2);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: sweep, write/read, bypass, scoreboard, set/clear collision, mid-run reset.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic CLK;
  logic RST;
  logic dbg_state;
  int   tests = 0;
  int   fails = 0;

  regfile_sb_if #(.XLEN(XLEN), .ADDR_W(AW)) bus ();

  regfile_sb #(.XLEN(XLEN), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // drivers
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.WE3 = 1'b0; bus.A3 = '0; bus.WD3 = '0;
    bus.SB_SET = 1'b0; bus.ASB = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 32) idle();
      #1;
      check(tag, {31'b0, bus.READY}, {31'b0, (i == 32)});
    end
  endtask

  logic byp;

  initial begin
`ifdef REGFILE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    RST = 1'b0;
    idle();
    bus.A1 = 5'd5; bus.A2 = 5'd7;
    #2;
    check("rst_ready", {31'b0, bus.READY}, 32'd0);
    check("rst_busy1", {31'b0, bus.BUSY1}, 32'd0);
    check("rst_rd1",   bus.RD1, 32'd0);
    check("rst_rd2",   bus.RD2, 32'd0);
    check("rst_state", {31'b0, dbg_state}, 32'd0);
    tick(); tick();

    // sweep with write and issue attempts that must be ignored
    @(negedge CLK);
    RST = 1'b1;
    bus.WE3 = 1'b1; bus.A3 = 5'd5; bus.WD3 = 32'hDEAD;
    bus.SB_SET = 1'b1; bus.ASB = 5'd5;
    #1;
    check("sweep_rd1", bus.RD1, 32'd0);
    sweep_check("sweep_ready");
    check("sweep_x5",    bus.RD1, 32'd0);
    check("sweep_busy5", {31'b0, bus.BUSY1}, 32'd0);
    check("run_state",   {31'b0, dbg_state}, 32'd1);

    // basic write / read and x0 write
    bus.WE3 = 1'b1; bus.A3 = 5'd7; bus.WD3 = 32'h12345678; bus.A1 = 5'd0;
    tick();
    idle(); bus.A1 = 5'd7; #1;
    check("wr_x7", bus.RD1, 32'h12345678);
    check("rd2_x7", bus.RD2, 32'h12345678);
    bus.WE3 = 1'b1; bus.A3 = 5'd0; bus.WD3 = 32'hFFFFFFFF; bus.A2 = 5'd0;
    tick();
    idle(); #1;
    check("x0_rd2",   bus.RD2, 32'd0);
    check("x0_busy2", {31'b0, bus.BUSY2}, 32'd0);

    // bypass
    bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'hA5A5A5A5; bus.A1 = 5'd3; #1;
    check("byp_rd1", bus.RD1, byp ? 32'hA5A5A5A5 : 32'd0);
    tick();
    idle(); #1;
    check("byp_after", bus.RD1, 32'hA5A5A5A5);

    // scoreboard set then clear
    bus.SB_SET = 1'b1; bus.ASB = 5'd9; bus.A1 = 5'd9; #1;
    check("sb_same_cyc", {31'b0, bus.BUSY1}, 32'd0);
    tick();
    idle(); #1;
    check("sb_set", {31'b0, bus.BUSY1}, 32'd1);
    bus.WE3 = 1'b1; bus.A3 = 5'd9; bus.WD3 = 32'h99; #1;
    check("sb_clr_cyc",  {31'b0, bus.BUSY1}, byp ? 32'd0 : 32'd1);
    check("sb_clr_data", bus.RD1, byp ? 32'h99 : 32'd0);
    tick();
    idle(); #1;
    check("sb_clr_next", {31'b0, bus.BUSY1}, 32'd0);
    check("sb_data_next", bus.RD1, 32'h99);

    // set/clear collision on x4
    bus.SB_SET = 1'b1; bus.ASB = 5'd4; bus.A2 = 5'd4;
    tick();
    idle(); #1;
    check("col_pre", {31'b0, bus.BUSY2}, 32'd1);
    bus.WE3 = 1'b1; bus.A3 = 5'd4; bus.WD3 = 32'h55;
    bus.SB_SET = 1'b1; bus.ASB = 5'd4; #1;
    check("col_busy_cyc", {31'b0, bus.BUSY2}, byp ? 32'd0 : 32'd1);
    check("col_rd_cyc",   bus.RD2, byp ? 32'h55 : 32'd0);
    tick();
    idle(); #1;
    check("col_busy", {31'b0, bus.BUSY2}, 32'd1);
    check("col_rd",   bus.RD2, 32'h55);

    // scoreboard set on x0 is dropped
    bus.SB_SET = 1'b1; bus.ASB = 5'd0; bus.A1 = 5'd0;
    tick();
    idle(); #1;
    check("x0_busy1", {31'b0, bus.BUSY1}, 32'd0);

    // mid-run reset
    bus.WE3 = 1'b1; bus.A3 = 5'd10; bus.WD3 = 32'h77;
    tick();
    idle(); bus.SB_SET = 1'b1; bus.ASB = 5'd10;
    tick();
    idle(); bus.A1 = 5'd10; #1;
    check("mr_rd",    bus.RD1, 32'h77);
    check("mr_busy",  {31'b0, bus.BUSY1}, 32'd1);
    check("mr_ready", {31'b0, bus.READY}, 32'd1);
    RST = 1'b0; #1;
    check("mr_rst_ready", {31'b0, bus.READY}, 32'd0);
    check("mr_rst_busy",  {31'b0, bus.BUSY1}, 32'd0);
    check("mr_rst_rd",    bus.RD1, 32'd0);
    check("mr_rst_state", {31'b0, dbg_state}, 32'd0);
    #1 RST = 1'b1;
    sweep_check("mr_sweep_ready");
    check("mr_x10",   bus.RD1, 32'd0);
    check("mr_busy10", {31'b0, bus.BUSY1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
